// File: rtl/anim_seq.sv
// Breathe-cycle sequencer for the duty/PWM stage: it issues start_up/down command
// pulses and waits for the duty stage's ready/ready_d completion levels.
module anim_seq #(
  parameter int unsigned HOLD_CYC = 1000,
  parameter int unsigned GAP_CYC  = 1000,
  parameter int unsigned TMO_CYC  = 65535,
  parameter int unsigned CNT_W    = 16
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic       i_go,
  input  logic       i_stop,
  input  logic [3:0] i_repeat_n,
  input  logic       i_ready,
  input  logic       i_ready_d,
  output logic       o_start_up,
  output logic       o_down,
  output logic       o_busy,
  output logic       o_done,
  output logic       o_err,
  output logic [3:0] o_loops,
  output logic [2:0] o_dbg_state
);

  // Handshake: start_up/down are one-cycle commands with no back-pressure; the duty
  // stage acknowledges by raising ready/ready_d, and only a 0->1 edge of the
  // registered level counts as completion.
  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_RISE = 3'd1,
    S_HOLD = 3'd2,
    S_FALL = 3'd3,
    S_GAP  = 3'd4
  } state_t;

  localparam longint unsigned CNT_MAX  = (64'd1 << CNT_W) - 64'd1;
  localparam longint unsigned HOLD_EFF = (HOLD_CYC == 0) ? 64'd1 : 64'(HOLD_CYC);
  localparam longint unsigned GAP_EFF  = (GAP_CYC == 0) ? 64'd1 : 64'(GAP_CYC);
  localparam longint unsigned TMO_EFF  = (TMO_CYC == 0) ? 64'd1 : 64'(TMO_CYC);
  // Limits clip to the counter range so a saturated counter still terminates.
  localparam logic [CNT_W-1:0] HOLD_LIM =
    CNT_W'((HOLD_EFF - 64'd1 > CNT_MAX) ? CNT_MAX : HOLD_EFF - 64'd1);
  localparam logic [CNT_W-1:0] GAP_LIM  =
    CNT_W'((GAP_EFF - 64'd1 > CNT_MAX) ? CNT_MAX : GAP_EFF - 64'd1);
  localparam logic [CNT_W-1:0] TMO_LIM  =
    CNT_W'((TMO_EFF - 64'd1 > CNT_MAX) ? CNT_MAX : TMO_EFF - 64'd1);

  state_t           r_state;
  state_t           w_state_nxt;
  logic [CNT_W-1:0] r_cnt;
  logic [3:0]       r_loops;
  logic [3:0]       r_rep;
  logic             r_stop_req;
  logic             r_ready_s;
  logic             r_ready_p;
  logic             r_ready_d_s;
  logic             r_ready_d_p;

  logic w_ready_rise;
  logic w_ready_d_rise;
  logic w_stop;
  logic w_more;
  logic w_hold_end;
  logic w_gap_end;
  logic w_tmo;
  logic w_accept;
  logic w_tmo_hit;
  logic w_start_up_nxt;
  logic w_down_nxt;
  logic w_busy_nxt;
  logic w_done_nxt;

  assign w_ready_rise   = r_ready_s & ~r_ready_p;
  assign w_ready_d_rise = r_ready_d_s & ~r_ready_d_p;
  assign w_stop         = i_stop | r_stop_req;
  assign w_more         = (r_rep == 4'd0) || (r_loops != r_rep);
  assign w_hold_end     = (r_cnt >= HOLD_LIM);
  assign w_gap_end      = (r_cnt >= GAP_LIM);
  assign w_tmo          = (r_cnt >= TMO_LIM);

  // State register
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state logic
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: begin
        if (i_go && !i_stop) w_state_nxt = S_RISE;
      end
      S_RISE: begin
        if (w_stop)            w_state_nxt = S_FALL;
        else if (w_ready_rise) w_state_nxt = S_HOLD;
        else if (w_tmo)        w_state_nxt = S_IDLE;
      end
      S_HOLD: begin
        if (w_stop || w_hold_end) w_state_nxt = S_FALL;
      end
      S_FALL: begin
        if (w_ready_d_rise) w_state_nxt = w_stop ? S_IDLE : S_GAP;
        else if (w_tmo)     w_state_nxt = S_IDLE;
      end
      S_GAP: begin
        if (w_stop)         w_state_nxt = S_IDLE;
        else if (w_gap_end) w_state_nxt = w_more ? S_RISE : S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Output logic: next values of the registered outputs
  always_comb begin
    w_accept       = 1'b0;
    w_tmo_hit      = 1'b0;
    w_start_up_nxt = 1'b0;
    w_down_nxt     = 1'b0;
    w_busy_nxt     = 1'b0;
    w_done_nxt     = 1'b0;
    w_accept       = (r_state == S_IDLE) && (w_state_nxt == S_RISE);
    w_tmo_hit      = ((r_state == S_RISE) && !w_stop && !w_ready_rise && w_tmo) ||
                     ((r_state == S_FALL) && !w_ready_d_rise && w_tmo);
    w_start_up_nxt = (w_state_nxt == S_RISE) && (r_state != S_RISE);
    w_down_nxt     = (w_state_nxt == S_FALL) && (r_state != S_FALL);
    w_busy_nxt     = (w_state_nxt != S_IDLE);
    w_done_nxt     = (r_state != S_IDLE) && (w_state_nxt == S_IDLE) && !w_tmo_hit;
  end

  // Datapath and registered outputs
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_cnt       <= '0;
      r_loops     <= 4'd0;
      r_rep       <= 4'd0;
      r_stop_req  <= 1'b0;
      r_ready_s   <= 1'b0;
      r_ready_p   <= 1'b0;
      r_ready_d_s <= 1'b0;
      r_ready_d_p <= 1'b0;
      o_start_up  <= 1'b0;
      o_down      <= 1'b0;
      o_busy      <= 1'b0;
      o_done      <= 1'b0;
      o_err       <= 1'b0;
    end else begin
      r_ready_s   <= i_ready;
      r_ready_p   <= r_ready_s;
      r_ready_d_s <= i_ready_d;
      r_ready_d_p <= r_ready_d_s;

      if (w_state_nxt != r_state) r_cnt <= '0;
      else if (r_state != S_IDLE && r_cnt != {CNT_W{1'b1}}) r_cnt <= r_cnt + CNT_W'(1);

      if (w_accept) begin
        r_loops <= 4'd0;
        r_rep   <= i_repeat_n;
      end else if (r_state == S_FALL && w_ready_d_rise) begin
        r_loops <= r_loops + 4'd1;
      end

      // A stop pulse is remembered until the sequence winds down.
      if (w_state_nxt == S_IDLE) r_stop_req <= 1'b0;
      else if (i_stop)           r_stop_req <= 1'b1;

      if (w_accept)       o_err <= 1'b0;
      else if (w_tmo_hit) o_err <= 1'b1;

      o_start_up <= w_start_up_nxt;
      o_down     <= w_down_nxt;
      o_busy     <= w_busy_nxt;
      o_done     <= w_done_nxt;
    end
  end

  assign o_loops     = r_loops;
  assign o_dbg_state = r_state;

endmodule

// File: tb/tb_anim_seq.sv
// Directed bench for anim_seq with a behavioural duty-stage model and a done/loops scoreboard.
module tb_anim_seq;

  localparam int HOLD = 4;
  localparam int GAP  = 3;
  localparam int TMO  = 20;
  localparam int LAT  = 10;
  localparam logic [2:0] ST_HOLD = 3'd2;
  localparam logic [2:0] ST_FALL = 3'd3;
  localparam logic [2:0] ST_GAP  = 3'd4;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       go;
  logic       stop;
  logic [3:0] repeat_n;
  logic       ready;
  logic       ready_d;
  logic       start_up;
  logic       down;
  logic       busy;
  logic       done;
  logic       err;
  logic [3:0] loops;
  logic [2:0] dbg_state;

  int n_cmp = 0;
  int n_err = 0;
  int cyc = 0;
  int n_up = 0;
  int n_down = 0;
  int n_done = 0;
  int up_tmr = 0;
  int dn_tmr = 0;
  int ready_t = -1;
  int last_up_t = 0;
  bit ready_en = 1'b1;
  bit meas_en = 1'b1;
  logic [3:0] exp_q[$];

  anim_seq #(.HOLD_CYC(HOLD), .GAP_CYC(GAP), .TMO_CYC(TMO), .CNT_W(16)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_go(go), .i_stop(stop), .i_repeat_n(repeat_n),
    .i_ready(ready), .i_ready_d(ready_d), .o_start_up(start_up), .o_down(down),
    .o_busy(busy), .o_done(done), .o_err(err), .o_loops(loops), .o_dbg_state(dbg_state)
  );

  // clock
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // One clock: sample just after the edge, run the duty model and the scoreboard.
  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
    if (up_tmr > 0) begin
      up_tmr--;
      if (up_tmr == 0) begin ready = 1'b1; ready_t = cyc; end
    end
    if (dn_tmr > 0) begin
      dn_tmr--;
      if (dn_tmr == 0) ready_d = 1'b1;
    end
    if (start_up || down) check("cmd_exclusive", {31'd0, start_up & down}, 0);
    if (start_up) begin
      n_up++;
      last_up_t = cyc;
      ready_d = 1'b0;
      dn_tmr = 0;
      if (ready_en) up_tmr = LAT;
    end
    if (down) begin
      n_down++;
      ready = 1'b0;
      up_tmr = 0;
      if (meas_en && ready_t >= 0) check("ready_to_down", cyc - ready_t, HOLD + 2);
      ready_t = -1;
      dn_tmr = LAT;
    end
    if (done) begin
      n_done++;
      check("done_expected", {31'd0, exp_q.size() > 0}, 1);
      if (exp_q.size() > 0) check("done_loops", {28'd0, loops}, {28'd0, exp_q.pop_front()});
    end
  endtask

  task automatic wait_done(input int budget);
    int start = n_done;
    int k = 0;
    while (n_done == start && k < budget) begin tick(); k++; end
    check("done_seen", {31'd0, n_done != start}, 1);
  endtask

  task automatic wait_state(input logic [2:0] st, input int budget);
    int k = 0;
    while (dbg_state != st && k < budget) begin tick(); k++; end
    check("reach_state", {29'd0, dbg_state}, {29'd0, st});
  endtask

  task automatic pulse_go(input logic [3:0] rep);
    repeat_n = rep;
    go = 1'b1;
    tick();
    go = 1'b0;
  endtask

  task automatic clear_counts();
    n_up = 0;
    n_down = 0;
    n_done = 0;
  endtask

  initial begin
    int k;
    rst_n = 1'b0; go = 1'b0; stop = 1'b0; repeat_n = 4'd0; ready = 1'b0; ready_d = 1'b0;

    // reset state
    repeat (3) tick();
    check("rst_start_up", {31'd0, start_up}, 0);
    check("rst_down", {31'd0, down}, 0);
    check("rst_busy", {31'd0, busy}, 0);
    check("rst_done", {31'd0, done}, 0);
    check("rst_err", {31'd0, err}, 0);
    check("rst_loops", {28'd0, loops}, 0);
    rst_n = 1'b1;
    tick();

    // two full breathe cycles
    clear_counts();
    exp_q.push_back(4'd2);
    pulse_go(4'd2);
    wait_done(400);
    check("two_busy_low", {31'd0, busy}, 0);
    check("two_up_count", n_up, 2);
    check("two_down_count", n_down, 2);
    check("two_loops", {28'd0, loops}, 2);
    repeat (10) tick();
    check("two_single_done", n_done, 1);
    check("two_no_extra_up", n_up, 2);

    // go held high restarts straight after done
    clear_counts();
    exp_q.push_back(4'd1);
    exp_q.push_back(4'd1);
    repeat_n = 4'd1;
    go = 1'b1;
    wait_done(300);
    tick();
    check("restart_start_up", {31'd0, start_up}, 1);
    go = 1'b0;
    wait_done(300);
    check("restart_up_count", n_up, 2);

    // stop during HOLD of the first cycle
    clear_counts();
    meas_en = 1'b0;
    exp_q.push_back(4'd1);
    pulse_go(4'd3);
    wait_state(ST_HOLD, 100);
    stop = 1'b1;
    tick();
    stop = 1'b0;
    check("stop_hold_down", {31'd0, down}, 1);
    wait_done(200);
    check("stop_hold_up", n_up, 1);
    check("stop_hold_down_cnt", n_down, 1);
    check("stop_hold_loops", {28'd0, loops}, 1);
    repeat (40) tick();
    check("stop_hold_no_restart", n_up, 1);
    meas_en = 1'b1;

    // ready never rises: timeout
    clear_counts();
    ready_en = 1'b0;
    pulse_go(4'd1);
    k = 0;
    while (busy && k < 100) begin tick(); k++; end
    check("tmo_idle", {31'd0, busy}, 0);
    check("tmo_cycles", cyc - last_up_t, TMO);
    check("tmo_err", {31'd0, err}, 1);
    check("tmo_no_done", n_done, 0);
    ready_en = 1'b1;
    exp_q.push_back(4'd1);
    pulse_go(4'd1);
    check("tmo_err_cleared", {31'd0, err}, 0);
    wait_done(300);

    // reset asserted during FALL of the second cycle
    clear_counts();
    exp_q.push_back(4'd2);
    pulse_go(4'd2);
    k = 0;
    while (!(dbg_state == ST_FALL && loops == 4'd1) && k < 300) begin tick(); k++; end
    check("reach_fall2_loops", {28'd0, loops}, 1);
    rst_n = 1'b0;
    #2;
    check("async_start_up", {31'd0, start_up}, 0);
    check("async_down", {31'd0, down}, 0);
    check("async_busy", {31'd0, busy}, 0);
    check("async_done", {31'd0, done}, 0);
    check("async_err", {31'd0, err}, 0);
    check("async_loops", {28'd0, loops}, 0);
    exp_q.delete();
    ready = 1'b0; ready_d = 1'b0; up_tmr = 0; dn_tmr = 0; ready_t = -1;
    repeat (2) tick();
    rst_n = 1'b1;
    clear_counts();
    repeat (30) tick();
    check("post_rst_no_up", n_up, 0);
    check("post_rst_no_down", n_down, 0);
    check("post_rst_no_done", n_done, 0);

    // endless mode, 17 cycles, loops wraps
    clear_counts();
    pulse_go(4'd0);
    k = 0;
    while (!(n_down == 17 && dbg_state == ST_GAP) && k < 2000) begin tick(); k++; end
    check("wrap_reach_gap", {29'd0, dbg_state}, {29'd0, ST_GAP});
    exp_q.push_back(4'd1);
    stop = 1'b1;
    tick();
    stop = 1'b0;
    check("wrap_stop_done", {31'd0, done}, 1);
    check("wrap_loops", {28'd0, loops}, 1);
    check("wrap_up_count", n_up, 17);
    check("wrap_busy_low", {31'd0, busy}, 0);
    check("queue_drained", exp_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
